// File: rtl/pulse_period_meter.sv
// Measures clocks between rising edges of PulseIn, with timeout and
// a valid/ack handshake that flags overwritten measurements.
module pulse_period_meter #(
  parameter int NBits = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             PulseIn,
  input  logic [NBits-1:0] TimeoutValue,
  input  logic             Ack,
  output logic [NBits-1:0] Period,
  output logic             Valid,
  output logic             Timeout,
  output logic             Missed
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  localparam logic [NBits-1:0] One = NBits'(1);

  state_t           state;
  logic [NBits-1:0] count;
  logic             pulse_q;
  logic             event_hit;
  logic             capture;
  logic             at_limit;

  assign event_hit = PulseIn & ~pulse_q;
  assign capture   = Enable & (state == MEASURE) & event_hit;
  assign at_limit  = (TimeoutValue != '0) && (count == TimeoutValue);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      count   <= '0;
      pulse_q <= 1'b0;
      Period  <= '0;
      Valid   <= 1'b0;
      Timeout <= 1'b0;
      Missed  <= 1'b0;
    end else begin
      pulse_q <= PulseIn;
      Timeout <= 1'b0;

      // A capture with a pending result flags Missed unless acked now
      if (capture) begin
        Period <= count;
        Valid  <= 1'b1;
        Missed <= Valid & ~Ack;
      end else if (Ack && Valid) begin
        Valid  <= 1'b0;
        Missed <= 1'b0;
      end

      if (!Enable) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            count <= '0;
            state <= ARMED;
          end
          ARMED: begin
            if (event_hit) begin
              count <= One;
              state <= MEASURE;
            end else begin
              count <= '0;
            end
          end
          MEASURE: begin
            if (event_hit) begin
              count <= One;
            end else if (at_limit) begin
              Timeout <= 1'b1;
              count   <= '0;
              state   <= ARMED;
            end else if (count != '1) begin
              count <= count + One;
            end
          end
          default: begin
            count <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
